preprocessing_stage: RTL and testbench

- First stage of the modulo (2^W − K) parallel-prefix adder.
- Forms bitwise generate/propagate/half-sum signals for operands a and b.
- Compresses a, b and the correction constant k into a carry-save pair (a_prim, b_prim), then forms generate/propagate/half-sum for that pair.
- Outputs are registered and feed the parallel-prefix stage. Only two prefix trees are needed downstream: one for a+b, one for a+b+k.

---
 rtl/preprocessing_stage.sv | 83 ++++++++
 tb/tb_preprocessing_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/preprocessing_stage.sv
// Preprocessing stage of the modulo (2^W - K) parallel-prefix adder.
// Registers g/p/h of (a,b) and of the CSA-compressed pair (a_prim,b_prim).
module preprocessing_stage #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] k,
    output logic             out_valid,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] a_prim,
    output logic [WIDTH-1:0] b_prim,
    output logic             csa_carry,
    output logic [WIDTH-1:0] g_prim,
    output logic [WIDTH-1:0] p_prim,
    output logic [WIDTH-1:0] h_prim
);

    logic [WIDTH-1:0] w_maj;
    logic [WIDTH-1:0] w_a_prim;
    logic [WIDTH-1:0] w_b_prim;

    logic             r_valid;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_a_prim;
    logic [WIDTH-1:0] r_b_prim;
    logic             r_csa_carry;
    logic [WIDTH-1:0] r_g_prim;
    logic [WIDTH-1:0] r_p_prim;
    logic [WIDTH-1:0] r_h_prim;

    // The top majority bit has weight 2^WIDTH and leaves via csa_carry.
    assign w_maj    = (a & b) | (a & k) | (b & k);
    assign w_a_prim = a ^ b ^ k;
    assign w_b_prim = {w_maj[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_g         <= '0;
            r_p         <= '0;
            r_h         <= '0;
            r_a_prim    <= '0;
            r_b_prim    <= '0;
            r_csa_carry <= 1'b0;
            r_g_prim    <= '0;
            r_p_prim    <= '0;
            r_h_prim    <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_g         <= a & b;
                r_p         <= a | b;
                r_h         <= a ^ b;
                r_a_prim    <= w_a_prim;
                r_b_prim    <= w_b_prim;
                r_csa_carry <= w_maj[WIDTH-1];
                r_g_prim    <= w_a_prim & w_b_prim;
                r_p_prim    <= w_a_prim | w_b_prim;
                r_h_prim    <= w_a_prim ^ w_b_prim;
            end
        end
    end

    assign out_valid = r_valid;
    assign g         = r_g;
    assign p         = r_p;
    assign h         = r_h;
    assign a_prim    = r_a_prim;
    assign b_prim    = r_b_prim;
    assign csa_carry = r_csa_carry;
    assign g_prim    = r_g_prim;
    assign p_prim    = r_p_prim;
    assign h_prim    = r_h_prim;

endmodule

// File: tb/tb_preprocessing_stage.sv
// Directed and randomized checks for preprocessing_stage.
// Directed vectors carry hand-computed expectations.
module tb_preprocessing_stage;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] a, b, k;
    logic         out_valid;
    logic [W-1:0] g, p, h, a_prim, b_prim, g_prim, p_prim, h_prim;
    logic         csa_carry;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    preprocessing_stage #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .k(k),
        .out_valid(out_valid),
        .g(g),
        .p(p),
        .h(h),
        .a_prim(a_prim),
        .b_prim(b_prim),
        .csa_carry(csa_carry),
        .g_prim(g_prim),
        .p_prim(p_prim),
        .h_prim(h_prim)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag,
                              input logic [W-1:0] eg, ep, eh,
                              input logic [W-1:0] eap, ebp,
                              input logic ecc,
                              input logic [W-1:0] egp, epp, ehp,
                              input logic eov);
        check({tag, ".g"}, 32'(g), 32'(eg));
        check({tag, ".p"}, 32'(p), 32'(ep));
        check({tag, ".h"}, 32'(h), 32'(eh));
        check({tag, ".a_prim"}, 32'(a_prim), 32'(eap));
        check({tag, ".b_prim"}, 32'(b_prim), 32'(ebp));
        check({tag, ".csa_carry"}, 32'(csa_carry), 32'(ecc));
        check({tag, ".g_prim"}, 32'(g_prim), 32'(egp));
        check({tag, ".p_prim"}, 32'(p_prim), 32'(epp));
        check({tag, ".h_prim"}, 32'(h_prim), 32'(ehp));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] sa, sb, sk;
        logic         shave;
        logic [8:0]   lhs, rhs;

        reset = 1'b0;
        in_valid = 1'b0;
        a = '0; b = '0; k = '0;
        #2;

        // Reset held with inputs toggling
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); k = W'($urandom);
            in_valid = 1'b1;
            tick();
            expect_all("rst_hold", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 1'b0,
                       7'b0, 7'b0, 7'b0, 1'b0);
        end

        #2 reset = 1'b1;
        in_valid = 1'b0;
        tick();
        expect_all("post_rst", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 1'b0,
                   7'b0, 7'b0, 7'b0, 1'b0);

        // Directed vector
        a = 7'b0111000; b = 7'b0111011; k = 7'b1101000; in_valid = 1'b1;
        tick();
        expect_all("vec1", 7'b0111000, 7'b0111011, 7'b0000011,
                   7'b1101011, 7'b1110000, 1'b0,
                   7'b1100000, 7'b1111011, 7'b0011011, 1'b1);

        // All ones
        a = 7'h7f; b = 7'h7f; k = 7'h7f; in_valid = 1'b1;
        tick();
        expect_all("ones", 7'h7f, 7'h7f, 7'h00,
                   7'h7f, 7'b1111110, 1'b1,
                   7'b1111110, 7'h7f, 7'b0000001, 1'b1);

        // Hold with changing inputs
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            a = 7'(i * 37 + 5); b = 7'(i * 11 + 90); k = 7'(i * 3 + 1);
            tick();
            expect_all("hold", 7'h7f, 7'h7f, 7'h00,
                       7'h7f, 7'b1111110, 1'b1,
                       7'b1111110, 7'h7f, 7'b0000001, 1'b0);
        end

        // k = 0
        a = 7'b1010101; b = 7'b0110011; k = 7'b0; in_valid = 1'b1;
        tick();
        expect_all("k0", 7'b0010001, 7'b1110111, 7'b1100110,
                   7'b1100110, 7'b0100010, 1'b0,
                   7'b0100010, 7'b1100110, 7'b1000100, 1'b1);

        // Asynchronous reset mid-stream
        a = 7'h7f; b = 7'h7f; k = 7'h7f; in_valid = 1'b1;
        tick();
        check("pre_async.csa_carry", 32'(csa_carry), 32'd1);
        #2 reset = 1'b0;
        #1;
        expect_all("async_rst", 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 1'b0,
                   7'b0, 7'b0, 7'b0, 1'b0);
        #2 reset = 1'b1;

        // Random: identity and bitwise relations against a 1-cycle scoreboard
        shave = 1'b0;
        sa = '0; sb = '0; sk = '0;
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom); b = W'($urandom); k = W'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid) begin
                sa = a; sb = b; sk = k; shave = 1'b1;
            end
            tick();
            check("rnd.out_valid", 32'(out_valid), 32'(in_valid));
            if (shave) begin
                lhs = 9'(sa) + 9'(sb) + 9'(sk);
                rhs = 9'(a_prim) + 9'(b_prim) + {csa_carry, 8'b0} * 9'd0
                      + (9'(csa_carry) << W);
                check("rnd.identity", 32'(rhs), 32'(lhs));
                check("rnd.g", 32'(g), 32'(sa & sb));
                check("rnd.p", 32'(p), 32'(sa | sb));
                check("rnd.h", 32'(h), 32'(sa ^ sb));
                check("rnd.a_prim", 32'(a_prim), 32'(sa ^ sb ^ sk));
                check("rnd.b_prim0", 32'(b_prim[0]), 32'd0);
                check("rnd.g_prim", 32'(g_prim), 32'(a_prim & b_prim));
                check("rnd.p_prim", 32'(p_prim), 32'(a_prim | b_prim));
                check("rnd.h_prim", 32'(h_prim), 32'(a_prim ^ b_prim));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
